// File: rtl/cpu_pkg.sv
// Shared CPU definitions: addressing modes, address-multiplexer select codes
// and the operand-fetch state enumeration.
package cpu_pkg;

    localparam logic [3:0] MODE_IMP  = 4'd0;
    localparam logic [3:0] MODE_IMM  = 4'd1;
    localparam logic [3:0] MODE_ZP   = 4'd2;
    localparam logic [3:0] MODE_ZPX  = 4'd3;
    localparam logic [3:0] MODE_ZPY  = 4'd4;
    localparam logic [3:0] MODE_ABS  = 4'd5;
    localparam logic [3:0] MODE_ABSX = 4'd6;
    localparam logic [3:0] MODE_ABSY = 4'd7;
    localparam logic [3:0] MODE_IND  = 4'd8;
    localparam logic [3:0] MODE_IZX  = 4'd9;
    localparam logic [3:0] MODE_IZY  = 4'd10;

    localparam logic [3:0] SEL_PC         = 4'b0000;
    localparam logic [3:0] SEL_ZP_DIR     = 4'b0001;
    localparam logic [3:0] SEL_DIR        = 4'b0010;
    localparam logic [3:0] SEL_ZP_IND     = 4'b0011;
    localparam logic [3:0] SEL_ZP_IND_INC = 4'b0100;
    localparam logic [3:0] SEL_IND        = 4'b0101;
    localparam logic [3:0] SEL_IND_INC    = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_LO,
        ST_FETCH_HI,
        ST_INDEX,
        ST_PTR_LO,
        ST_PTR_HI,
        ST_DONE
    } state_t;

    // Pointer-based modes fetch their operand bytes into indirl/indirh.
    function automatic logic is_indirect(input logic [3:0] m);
        return (m == MODE_IND) || (m == MODE_IZX) || (m == MODE_IZY);
    endfunction

    function automatic logic uses_y(input logic [3:0] m);
        return (m == MODE_ZPY) || (m == MODE_ABSY) || (m == MODE_IZY);
    endfunction

endpackage

// File: rtl/index_adder.sv
// 16-bit base plus 8-bit index; carry7 is the carry out of the low byte and
// also serves as the page-cross indication.
module index_adder (
    input  logic [15:0] base,
    input  logic [7:0]  idx,
    output logic [15:0] sum,
    output logic        carry7
);

    logic [8:0] low_sum;

    assign low_sum = {1'b0, base[7:0]} + {1'b0, idx};
    assign carry7  = low_sum[8];
    assign sum     = {base[15:8] + {7'b0, low_sum[8]}, low_sum[7:0]};

endmodule

// File: rtl/operand_fetch_seq.sv
// Operand/addressing-mode sequencer: drives address-select codes, captures
// operand and pointer bytes, applies X/Y indexing and flags completion.
module operand_fetch_seq
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] mode,
    input  logic [7:0] data_in,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [3:0] address_select,
    output logic       pc_inc,
    output logic [7:0] dirl,
    output logic [7:0] dirh,
    output logic [7:0] indirl,
    output logic [7:0] indirh,
    output logic       busy,
    output logic       done,
    output logic       page_cross
);

    state_t      state, next_state;
    logic [3:0]  mode_q;
    logic [15:0] idx_base, idx_sum;
    logic [7:0]  idx_val;
    logic        idx_carry;

    function automatic state_t first_state(input logic [3:0] m);
        if (m >= MODE_ZP && m <= MODE_IZY)
            return ST_FETCH_LO;
        return ST_DONE;
    endfunction

    function automatic logic [3:0] effective_select(input logic [3:0] m);
        if (m == MODE_ZP || m == MODE_ZPX || m == MODE_ZPY)
            return SEL_ZP_DIR;
        if (m >= MODE_ABS && m <= MODE_IZY)
            return SEL_DIR;
        return SEL_PC;
    endfunction

    assign idx_val  = uses_y(mode_q) ? y : x;
    assign idx_base = (mode_q == MODE_IZX) ? {8'h00, indirl} : {dirh, dirl};

    index_adder u_index_adder (
        .base   (idx_base),
        .idx    (idx_val),
        .sum    (idx_sum),
        .carry7 (idx_carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        address_select = SEL_PC;
        pc_inc         = 1'b0;
        done           = 1'b0;
        busy           = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start)
                    next_state = first_state(mode);
            end
            ST_FETCH_LO: begin
                pc_inc = 1'b1;
                case (mode_q)
                    MODE_ZPX, MODE_ZPY, MODE_IZX:           next_state = ST_INDEX;
                    MODE_ABS, MODE_ABSX, MODE_ABSY, MODE_IND: next_state = ST_FETCH_HI;
                    MODE_IZY:                               next_state = ST_PTR_LO;
                    default:                                next_state = ST_DONE;
                endcase
            end
            ST_FETCH_HI: begin
                pc_inc = 1'b1;
                case (mode_q)
                    MODE_ABSX, MODE_ABSY: next_state = ST_INDEX;
                    MODE_IND:             next_state = ST_PTR_LO;
                    default:              next_state = ST_DONE;
                endcase
            end
            ST_INDEX: begin
                next_state = (mode_q == MODE_IZX) ? ST_PTR_LO : ST_DONE;
            end
            ST_PTR_LO: begin
                address_select = (mode_q == MODE_IND) ? SEL_IND : SEL_ZP_IND;
                next_state     = ST_PTR_HI;
            end
            ST_PTR_HI: begin
                address_select = (mode_q == MODE_IND) ? SEL_IND_INC : SEL_ZP_IND_INC;
                next_state     = (mode_q == MODE_IZY) ? ST_INDEX : ST_DONE;
            end
            ST_DONE: begin
                address_select = effective_select(mode_q);
                done           = 1'b1;
                next_state     = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= '0;
            dirl       <= '0;
            dirh       <= '0;
            indirl     <= '0;
            indirh     <= '0;
            page_cross <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        page_cross <= 1'b0;
                    end
                end
                ST_FETCH_LO: begin
                    if (is_indirect(mode_q))
                        indirl <= data_in;
                    else
                        dirl <= data_in;
                end
                ST_FETCH_HI: begin
                    if (mode_q == MODE_IND)
                        indirh <= data_in;
                    else
                        dirh <= data_in;
                end
                ST_PTR_LO: dirl <= data_in;
                ST_PTR_HI: dirh <= data_in;
                ST_INDEX: begin
                    case (mode_q)
                        MODE_ZPX, MODE_ZPY: dirl <= idx_sum[7:0];
                        MODE_ABSX, MODE_ABSY, MODE_IZY: begin
                            {dirh, dirl} <= idx_sum;
                            page_cross   <= idx_carry;
                        end
                        MODE_IZX: indirl <= idx_sum[7:0];
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Randomized bench for operand_fetch_seq: a memory array plus an address-level
// model of each addressing mode predicts selects, pulses and final registers.
module tb_operand_fetch_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] mode;
    logic [7:0] data_in, x, y;
    logic [3:0] address_select;
    logic       pc_inc, busy, done, page_cross;
    logic [7:0] dirl, dirh, indirl, indirh;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] pc;
    logic [7:0]  m_dirl, m_dirh, m_indirl, m_indirh;
    logic        m_pc;

    typedef struct {
        logic [3:0]  sel;
        logic        inc;
        logic [15:0] addr;
    } step_t;

    always #5 clk = ~clk;

    operand_fetch_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .data_in        (data_in),
        .x              (x),
        .y              (y),
        .address_select (address_select),
        .pc_inc         (pc_inc),
        .dirl           (dirl),
        .dirh           (dirh),
        .indirl         (indirl),
        .indirh         (indirh),
        .busy           (busy),
        .done           (done),
        .page_cross     (page_cross)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic step_t stp(input logic [3:0] s, input logic i, input logic [15:0] a);
        step_t r;
        r.sel  = s;
        r.inc  = i;
        r.addr = a;
        return r;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".dirl"},   {8'h00, dirl},   {8'h00, m_dirl});
        check({tag, ".dirh"},   {8'h00, dirh},   {8'h00, m_dirh});
        check({tag, ".indirl"}, {8'h00, indirl}, {8'h00, m_indirl});
        check({tag, ".indirh"}, {8'h00, indirh}, {8'h00, m_indirh});
        check({tag, ".page_cross"}, {15'h0, page_cross}, {15'h0, m_pc});
    endtask

    // Plans the bus cycles of one operand fetch from addressing-mode rules,
    // then drives memory data and checks every cycle plus the final registers.
    task automatic run_op(input logic [3:0] m, input bit noise);
        step_t       plan[$];
        logic [7:0]  b0, b1, zp;
        logic [15:0] ptr, base;
        logic [3:0]  final_sel;
        int          s;
        b0 = mem[pc];
        b1 = mem[pc + 16'd1];
        m_pc = 1'b0;
        final_sel = 4'd0;
        case (m)
            4'd2: begin
                plan.push_back(stp(4'd0, 1'b1, pc));
                m_dirl = b0; final_sel = 4'd1;
            end
            4'd3, 4'd4: begin
                plan.push_back(stp(4'd0, 1'b1, pc));
                plan.push_back(stp(4'd0, 1'b0, 16'h0));
                s = int'(b0) + int'(m == 4'd3 ? x : y);
                m_dirl = 8'(s % 256); final_sel = 4'd1;
            end
            4'd5: begin
                plan.push_back(stp(4'd0, 1'b1, pc));
                plan.push_back(stp(4'd0, 1'b1, pc + 16'd1));
                m_dirl = b0; m_dirh = b1; final_sel = 4'd2;
            end
            4'd6, 4'd7: begin
                plan.push_back(stp(4'd0, 1'b1, pc));
                plan.push_back(stp(4'd0, 1'b1, pc + 16'd1));
                plan.push_back(stp(4'd0, 1'b0, 16'h0));
                s = int'(b0) + int'(m == 4'd6 ? x : y);
                m_pc = (s > 255);
                s = (int'(b1) * 256 + s) % 65536;
                m_dirl = 8'(s % 256); m_dirh = 8'(s / 256); final_sel = 4'd2;
            end
            4'd8: begin
                ptr = {b1, b0};
                plan.push_back(stp(4'd0, 1'b1, pc));
                plan.push_back(stp(4'd0, 1'b1, pc + 16'd1));
                plan.push_back(stp(4'd5, 1'b0, ptr));
                plan.push_back(stp(4'd6, 1'b0, ptr + 16'd1));
                m_indirl = b0; m_indirh = b1;
                m_dirl = mem[ptr]; m_dirh = mem[ptr + 16'd1]; final_sel = 4'd2;
            end
            4'd9: begin
                zp = 8'((int'(b0) + int'(x)) % 256);
                plan.push_back(stp(4'd0, 1'b1, pc));
                plan.push_back(stp(4'd0, 1'b0, 16'h0));
                plan.push_back(stp(4'd3, 1'b0, {8'h00, zp}));
                plan.push_back(stp(4'd4, 1'b0, {8'h00, zp + 8'd1}));
                m_indirl = zp;
                m_dirl = mem[{8'h00, zp}]; m_dirh = mem[{8'h00, zp + 8'd1}]; final_sel = 4'd2;
            end
            4'd10: begin
                plan.push_back(stp(4'd0, 1'b1, pc));
                plan.push_back(stp(4'd3, 1'b0, {8'h00, b0}));
                plan.push_back(stp(4'd4, 1'b0, {8'h00, b0 + 8'd1}));
                plan.push_back(stp(4'd0, 1'b0, 16'h0));
                base = {mem[{8'h00, b0 + 8'd1}], mem[{8'h00, b0}]};
                m_indirl = b0;
                m_pc = (int'(base[7:0]) + int'(y)) > 255;
                s = (int'(base) + int'(y)) % 65536;
                m_dirl = 8'(s % 256); m_dirh = 8'(s / 256); final_sel = 4'd2;
            end
            default: final_sel = 4'd0;
        endcase

        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = 4'($urandom);
        foreach (plan[i]) begin
            check($sformatf("m%0d.c%0d.sel", m, i), {12'h0, address_select}, {12'h0, plan[i].sel});
            check($sformatf("m%0d.c%0d.pc_inc", m, i), {15'h0, pc_inc}, {15'h0, plan[i].inc});
            check($sformatf("m%0d.c%0d.done", m, i), {15'h0, done}, 16'h0);
            check($sformatf("m%0d.c%0d.busy", m, i), {15'h0, busy}, 16'h1);
            data_in = mem[plan[i].addr];
            if (plan[i].inc)
                pc = pc + 16'd1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                mode  = 4'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
        end
        check($sformatf("m%0d.done", m), {15'h0, done}, 16'h1);
        check($sformatf("m%0d.eff_sel", m), {12'h0, address_select}, {12'h0, final_sel});
        check($sformatf("m%0d.done_pc_inc", m), {15'h0, pc_inc}, 16'h0);
        data_in = 8'($urandom);
        @(negedge clk);
        check($sformatf("m%0d.idle_busy", m), {15'h0, busy}, 16'h0);
        check($sformatf("m%0d.idle_done", m), {15'h0, done}, 16'h0);
        check_regs($sformatf("m%0d", m));
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        mode    = 4'd0;
        data_in = 8'h00;
        x       = 8'h00;
        y       = 8'h00;
        pc      = 16'h0400;
        m_dirl = 8'h00; m_dirh = 8'h00; m_indirl = 8'h00; m_indirh = 8'h00; m_pc = 1'b0;
        for (int i = 0; i < 65536; i++)
            mem[i] = 8'($urandom);

        repeat (2) @(negedge clk);
        check("rst.sel", {12'h0, address_select}, 16'h0);
        check("rst.busy", {15'h0, busy}, 16'h0);
        check("rst.done", {15'h0, done}, 16'h0);
        check("rst.pc_inc", {15'h0, pc_inc}, 16'h0);
        check_regs("rst");
        reset = 1'b0;

        // Abort an ABS fetch after its low byte has been captured.
        mem[pc] = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        mode  = 4'd5;
        @(negedge clk);
        start   = 1'b0;
        data_in = mem[pc];
        pc = pc + 16'd1;
        @(negedge clk);
        check("abort.busy_before", {15'h0, busy}, 16'h1);
        check("abort.dirl_before", {8'h00, dirl}, 16'h005A);
        reset = 1'b1;
        #1;
        check("abort.busy", {15'h0, busy}, 16'h0);
        check("abort.sel", {12'h0, address_select}, 16'h0);
        check("abort.pc_inc", {15'h0, pc_inc}, 16'h0);
        check("abort.dirl", {8'h00, dirl}, 16'h0);
        repeat (2) begin
            @(negedge clk);
            check("abort.no_done", {15'h0, done}, 16'h0);
        end
        reset = 1'b0;
        pc = 16'h0400;
        run_op(4'd5, 1'b0);

        // ZPX wrap.
        mem[pc] = 8'hF0;
        x = 8'h20;
        run_op(4'd3, 1'b0);
        // ABSY with and without page cross.
        mem[pc] = 8'hFF; mem[pc + 16'd1] = 8'h12; y = 8'h01;
        run_op(4'd7, 1'b0);
        mem[pc] = 8'h10; mem[pc + 16'd1] = 8'h12;
        run_op(4'd7, 1'b0);
        check("absy.dir", {dirh, dirl}, 16'h1211);
        // IND through 02FF/0300.
        mem[pc] = 8'hFF; mem[pc + 16'd1] = 8'h02; mem[16'h02FF] = 8'h34; mem[16'h0300] = 8'h12;
        run_op(4'd8, 1'b0);
        check("ind.dir", {dirh, dirl}, 16'h1234);
        // IZY.
        mem[pc] = 8'h80; mem[16'h0080] = 8'h00; mem[16'h0081] = 8'h40; y = 8'h05;
        run_op(4'd10, 1'b0);
        check("izy.dir", {dirh, dirl}, 16'h4005);
        // IZX wrap with start noise while busy, then an out-of-range mode.
        mem[pc] = 8'hFE; x = 8'h03;
        run_op(4'd9, 1'b1);
        check("izx.indirl", {8'h00, indirl}, 16'h0001);
        run_op(4'd13, 1'b0);

        // Start held through DONE is taken only once back in IDLE.
        @(negedge clk);
        start = 1'b1;
        mode  = 4'd0;
        @(negedge clk);
        check("hold.done1", {15'h0, done}, 16'h1);
        @(negedge clk);
        check("hold.idle", {15'h0, busy}, 16'h0);
        @(negedge clk);
        check("hold.done2", {15'h0, done}, 16'h1);
        start = 1'b0;
        @(negedge clk);
        check("hold.end", {15'h0, busy}, 16'h0);
        m_pc = 1'b0;
        check_regs("hold");

        for (int n = 0; n < 200; n++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            if (($urandom % 8) == 0)
                pc = 16'($urandom);
            run_op(4'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
